// File: rtl/rf_wr_arbiter.sv
// Round-robin write-port arbiter for the register file, with a registered write stage and handshake violation detection.
// Optional macro RF_ARB_BYPASS_EN: forwards the in-flight write to the read port when the indices match.
module rf_wr_arbiter #(
  parameter int REGWIDTH = 16,
  parameter int REGADDR  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aValid,
  input  logic [REGADDR-1:0]  aReg,
  input  logic [REGWIDTH-1:0] aData,
  output logic                aReady,
  input  logic                bValid,
  input  logic [REGADDR-1:0]  bReg,
  input  logic [REGWIDTH-1:0] bData,
  output logic                bReady,
  input  logic                hold,
  output logic                wrEn,
  output logic [REGADDR-1:0]  wrReg,
  output logic [REGWIDTH-1:0] wrData,
  input  logic [REGADDR-1:0]  rdReg,
  input  logic [REGWIDTH-1:0] rfRdData,
  output logic [REGWIDTH-1:0] rdData,
  output logic                err
);

  // Handshake: a transfer happens in any cycle where valid & ready are both high.
  // Once valid rises, the requester must hold valid, reg and data stable until it
  // sees ready; ready is combinational and may be observed in the same cycle.

  logic                prio;       // 0: A wins a tie, 1: B wins a tie
  logic                contested;
  logic                a_wait, b_wait;
  logic [REGADDR-1:0]  a_reg_q, b_reg_q;
  logic [REGWIDTH-1:0] a_data_q, b_data_q;
  logic                a_bad, b_bad;

  always_comb begin
    aReady    = 1'b0;
    bReady    = 1'b0;
    contested = aValid & bValid & ~hold;
    if (!hold) begin
      aReady = aValid & (~bValid | ~prio);
      bReady = bValid & (~aValid | prio);
    end
  end

  // A requester left waiting last cycle must not retract or alter its request.
  assign a_bad = a_wait & (~aValid | (aReg != a_reg_q) | (aData != a_data_q));
  assign b_bad = b_wait & (~bValid | (bReg != b_reg_q) | (bData != b_data_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      wrEn     <= 1'b0;
      wrReg    <= '0;
      wrData   <= '0;
      err      <= 1'b0;
      a_wait   <= 1'b0;
      b_wait   <= 1'b0;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      // The loser of a contest gets the next tie.
      if (contested) prio <= ~prio;
      wrEn <= aReady | bReady;
      if (aReady) begin
        wrReg  <= aReg;
        wrData <= aData;
      end else if (bReady) begin
        wrReg  <= bReg;
        wrData <= bData;
      end
      err      <= a_bad | b_bad;
      a_wait   <= aValid & ~aReady;
      b_wait   <= bValid & ~bReady;
      a_reg_q  <= aReg;
      b_reg_q  <= bReg;
      a_data_q <= aData;
      b_data_q <= bData;
    end
  end

`ifdef RF_ARB_BYPASS_EN
  assign rdData = (wrEn && (wrReg == rdReg)) ? wrData : rfRdData;
`else
  logic unused_rd;
  assign unused_rd = ^rdReg;
  assign rdData    = rfRdData;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a rule-level model checked every cycle plus directed scenarios with literal expectations.
module tb_rf_wr_arbiter;
  localparam int RW = 16;
  localparam int RA = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          aValid, bValid, hold;
  logic [RA-1:0] aReg, bReg, rdReg;
  logic [RW-1:0] aData, bData;
  logic          aReady, bReady, wrEn, err;
  logic [RA-1:0] wrReg;
  logic [RW-1:0] wrData, rdData, rfRdData;

  logic [RW-1:0] rf_mem [8] = '{default: '0};

  int n_chk  = 0;
  int n_fail = 0;

  rf_wr_arbiter #(.REGWIDTH(RW), .REGADDR(RA)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aReg(aReg), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bReg(bReg), .bData(bData), .bReady(bReady),
    .hold(hold), .wrEn(wrEn), .wrReg(wrReg), .wrData(wrData),
    .rdReg(rdReg), .rfRdData(rfRdData), .rdData(rdData), .err(err)
  );

  // clock / environment: the register file itself
  always #5 clk = ~clk;
  assign rfRdData = rf_mem[rdReg];
  always @(posedge clk) if (wrEn) rf_mem[wrReg] <= wrData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // behavioural model: expected writes and retire order
  logic [RA+RW-1:0] exp_q [$];
  logic          m_tie_to_b = 1'b0;
  logic          m_wr_en = 1'b0, m_err = 1'b0;
  logic [RA-1:0] m_wr_reg = '0;
  logic [RW-1:0] m_wr_data = '0;
  logic          m_a_wait = 1'b0, m_b_wait = 1'b0;
  logic [RA-1:0] m_a_reg, m_b_reg;
  logic [RW-1:0] m_a_data, m_b_data;
  logic          ga, gb, viol;
  logic [RW-1:0] exp_rd;
  logic [RA+RW-1:0] head;

  always @(negedge clk) begin
    ga = !hold && aValid && (!bValid || !m_tie_to_b);
    gb = !hold && bValid && (!aValid || m_tie_to_b);
    chk("a_ready", aReady, ga);
    chk("b_ready", bReady, gb);
    chk("wr_en", wrEn, m_wr_en);
    chk("wr_reg", wrReg, m_wr_reg);
    chk("wr_data", wrData, m_wr_data);
    chk("err", err, m_err);
`ifdef RF_ARB_BYPASS_EN
    exp_rd = (m_wr_en && m_wr_reg == rdReg) ? m_wr_data : rfRdData;
`else
    exp_rd = rfRdData;
`endif
    chk("rd_data", rdData, exp_rd);
    if (wrEn) begin
      if (exp_q.size() == 0) chk("retire_unexpected", 1, 0);
      else begin
        head = exp_q.pop_front();
        chk("retire_order", {wrReg, wrData}, head);
      end
    end
    // advance the model by one clock using the current inputs
    if (rst) begin
      m_tie_to_b = 1'b0; m_wr_en = 1'b0; m_wr_reg = '0; m_wr_data = '0;
      m_err = 1'b0; m_a_wait = 1'b0; m_b_wait = 1'b0;
    end else begin
      viol = (m_a_wait && (!aValid || aReg != m_a_reg || aData != m_a_data)) ||
             (m_b_wait && (!bValid || bReg != m_b_reg || bData != m_b_data));
      m_err = viol;
      m_wr_en = ga || gb;
      if (ga) begin m_wr_reg = aReg; m_wr_data = aData; end
      if (gb) begin m_wr_reg = bReg; m_wr_data = bData; end
      if (ga || gb) exp_q.push_back({m_wr_reg, m_wr_data});
      if (aValid && bValid && !hold) m_tie_to_b = ga;  // loser gets the next tie
      m_a_wait = aValid && !ga;
      m_b_wait = bValid && !gb;
    end
    m_a_reg = aReg; m_a_data = aData; m_b_reg = bReg; m_b_data = bData;
  end

  // driver tasks
  task automatic set_in(input logic av, input logic [RA-1:0] ar, input logic [RW-1:0] ad,
                        input logic bv, input logic [RA-1:0] br, input logic [RW-1:0] bd,
                        input logic h);
    aValid = av; aReg = ar; aData = ad;
    bValid = bv; bReg = br; bData = bd;
    hold = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rdReg = 0;
    // reset with both requesters valid
    rst = 1'b1;
    set_in(1, 1, 16'h1111, 1, 2, 16'h2222, 0);
    @(negedge clk);
    chk("rst_wr_en", wrEn, 0);
    chk("rst_wr_reg", wrReg, 0);
    chk("rst_wr_data", wrData, 0);
    chk("rst_err", err, 0);
    cycle(); cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("first_grant_a", aReady, 1);
    chk("first_grant_not_b", bReady, 0);
    cycle();
    set_in(0, 0, 0, 1, 2, 16'h2222, 0);
    @(negedge clk);
    chk("b_after_a", bReady, 1);
    chk("first_wr_data", wrData, 16'h1111);
    cycle();
    idle();
    @(negedge clk);
    chk("second_wr_data", wrData, 16'h2222);
    cycle();

    // uncontested write and file latency
    set_in(1, 3, 16'hBEEF, 0, 0, 0, 0);
    rdReg = 3;
    @(negedge clk);
    chk("unc_a_ready", aReady, 1);
    cycle();
    idle();
    @(negedge clk);
    chk("unc_wr_en", wrEn, 1);
    chk("unc_wr_reg", wrReg, 3);
    chk("unc_wr_data", wrData, 16'hBEEF);
    cycle();
    @(negedge clk);
    chk("unc_file_read", rdData, 16'hBEEF);
    chk("unc_wr_en_off", wrEn, 0);
    cycle();

    // round-robin: A,B,A,B
    do_reset();
    set_in(1, 1, 16'hA001, 1, 2, 16'hB001, 0);
    @(negedge clk); chk("rr1_a", aReady, 1);
    cycle();
    set_in(1, 1, 16'hA002, 1, 2, 16'hB001, 0);
    @(negedge clk); chk("rr2_b", bReady, 1); chk("rr_data1", wrData, 16'hA001);
    cycle();
    set_in(1, 1, 16'hA002, 1, 2, 16'hB002, 0);
    @(negedge clk); chk("rr3_a", aReady, 1); chk("rr_data2", wrData, 16'hB001);
    cycle();
    set_in(0, 0, 0, 1, 2, 16'hB002, 0);
    @(negedge clk); chk("rr4_b", bReady, 1); chk("rr_data3", wrData, 16'hA002);
    cycle();
    idle();
    @(negedge clk); chk("rr_data4", wrData, 16'hB002);
    cycle();

    // hold freezes grants
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 4, 16'hC0DE, 1, 5, 16'hD00D, 1);
      @(negedge clk);
      chk("hold_a", aReady, 0);
      chk("hold_b", bReady, 0);
      chk("hold_wr_en", wrEn, 0);
      chk("hold_err", err, 0);
      cycle();
    end
    set_in(1, 4, 16'hC0DE, 1, 5, 16'hD00D, 0);
    @(negedge clk); chk("unhold_a", aReady, 1);
    cycle();
    set_in(0, 0, 0, 1, 5, 16'hD00D, 0);
    @(negedge clk); chk("unhold_b", bReady, 1); chk("unhold_data", wrData, 16'hC0DE);
    cycle();
    idle();
    @(negedge clk); chk("unhold_err", err, 0);
    cycle();

    // violation: waiting B changes data
    do_reset();
    set_in(1, 6, 16'hAAAA, 1, 7, 16'hBBBB, 0);
    cycle();
    set_in(0, 0, 0, 1, 7, 16'hBBBC, 0);
    @(negedge clk); chk("viol_b_ready", bReady, 1); chk("viol_err_pre", err, 0);
    cycle();
    idle();
    @(negedge clk); chk("viol_change_err", err, 1); chk("viol_data", wrData, 16'hBBBC);
    cycle();
    @(negedge clk); chk("viol_err_clear", err, 0);
    cycle();

    // reset while B is waiting: no error
    do_reset();
    set_in(1, 6, 16'hAAAA, 1, 7, 16'hBBBB, 0);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk); chk("rst_inflight_err", err, 0);
    cycle();

    // violation: waiting B drops valid
    set_in(1, 6, 16'hAAAA, 1, 7, 16'hBBBB, 0);
    cycle();
    idle();
    cycle();
    @(negedge clk); chk("viol_drop_err", err, 1);
    cycle();
    @(negedge clk); chk("viol_drop_clear", err, 0);
    cycle();

    // same destination from both; later grant wins in the file
    set_in(1, 5, 16'h1234, 1, 5, 16'h5678, 0);
    @(negedge clk); chk("same_b_first", bReady, 1);
    cycle();
    set_in(1, 5, 16'h1234, 0, 0, 0, 0);
    @(negedge clk); chk("same_a_second", aReady, 1);
    cycle();
    idle();
    rdReg = 5;
    @(negedge clk);
    chk("same_wr_data", wrData, 16'h1234);
`ifdef RF_ARB_BYPASS_EN
    chk("bypass_rd", rdData, 16'h1234);
`else
    chk("nobypass_rd", rdData, 16'h5678);
`endif
    cycle();
    @(negedge clk); chk("same_final_rd", rdData, 16'h1234);
    cycle();
    cycle();

    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
